// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS fetch stage and the downstream
// control unit. This covers the reset PC, the NOP word, the PC step, the
// opcode field position and the opcode encodings.
package mips_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] PC_STEP  = 32'd4;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 26;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // Extract the opcode field of an instruction word.
   function automatic logic [5:0] get_op(input logic [31:0] instr);
      return instr[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between the fetch stage and imem.
//   imem_addr  : byte address driven by the fetch stage (master)
//   imem_rdata : instruction word, combinational read of imem_addr (slave)
interface fetch_stage_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst       : clock, synchronous active-high reset
//   en_i           : load enable (low = stall/hold)
//   flush_i        : load NOP_WORD with valid cleared (wins over en_i)
//   instr_i        : fetched instruction word
//   pc_plus4_i     : PC + 4 of the fetched instruction
//   instr_o        : registered instruction word
//   pc_plus4_o     : registered PC + 4
//   valid_o        : set when the register holds a real fetched instruction
module if_id_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        flush_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_plus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   logic [31:0] instr_q;
   logic [31:0] pc_plus4_q;
   logic        valid_q;

   // IF/ID state: reset, then flush, then load, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q    <= NOP_WORD;
         pc_plus4_q <= 32'h0000_0000;
         valid_q    <= 1'b0;
      end else if (flush_i) begin
         instr_q    <= NOP_WORD;
         pc_plus4_q <= 32'h0000_0000;
         valid_q    <= 1'b0;
      end else if (en_i) begin
         instr_q    <= instr_i;
         pc_plus4_q <= pc_plus4_i;
         valid_q    <= 1'b1;
      end else begin
         instr_q    <= instr_q;
         pc_plus4_q <= pc_plus4_q;
         valid_q    <= valid_q;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage with the PC register, the next-PC
// mux and the IF/ID register.
//   clk, rst        : clock, synchronous active-high reset
//   stall_i         : hold PC, IF/ID and fetch counter
//   redirect_i      : taken branch/jump, overrides stall and flushes IF/ID
//   redirect_pc_i   : redirect target; the low two bits are dropped
//   imem            : instruction-memory bus (addr = pc_q, rdata same cycle)
//   id_instr_o      : IF/ID instruction
//   id_op_o         : opcode slice of id_instr_o, for the control unit
//   id_pc_plus4_o   : IF/ID PC + 4
//   id_valid_o      : IF/ID holds a real instruction
//   misalign_o      : sticky flag, a redirect target was not word aligned
//   fetch_count_o   : instructions latched into IF/ID (wraps at 2^32)
module fetch_stage
   import mips_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 redirect_i,
   input  logic [31:0]          redirect_pc_i,
   fetch_stage_if.master        imem,
   output logic [31:0]          id_instr_o,
   output logic [5:0]           id_op_o,
   output logic [31:0]          id_pc_plus4_o,
   output logic                 id_valid_o,
   output logic                 misalign_o,
   output logic [31:0]          fetch_count_o
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] count_q, count_d;
   logic        misalign_q, misalign_d;
   logic [31:0] pc_plus4_s;
   logic        load_s;

   assign pc_plus4_s = pc_q + PC_STEP;  // modulo 2^32
   assign load_s     = ~stall_i & ~redirect_i;

   // Next-state selection for PC, fetch counter and misalign flag.
   always_comb begin
      pc_d       = pc_q;
      count_d    = count_q;
      misalign_d = misalign_q;
      if (redirect_i) begin
         pc_d = {redirect_pc_i[31:2], 2'b00};
         if (redirect_pc_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end else begin
            misalign_d = misalign_q;
         end
      end else if (stall_i) begin
         pc_d    = pc_q;
         count_d = count_q;
      end else begin
         pc_d    = pc_plus4_s;
         count_d = count_q + 32'd1;
      end
   end

   // PC, counter and sticky misalign registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         count_q    <= 32'h0000_0000;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
      end
   end

   if_id_reg u_if_id (
      .clk        (clk),
      .rst        (rst),
      .en_i       (load_s),
      .flush_i    (redirect_i),
      .instr_i    (imem.imem_rdata),
      .pc_plus4_i (pc_plus4_s),
      .instr_o    (id_instr_o),
      .pc_plus4_o (id_pc_plus4_o),
      .valid_o    (id_valid_o)
   );

   assign imem.imem_addr = pc_q;
   assign id_op_o        = get_op(id_instr_o);
   assign misalign_o     = misalign_q;
   assign fetch_count_o  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] id_instr_o;
   logic [5:0]  id_op_o;
   logic [31:0] id_pc_plus4_o;
   logic        id_valid_o;
   logic        misalign_o;
   logic [31:0] fetch_count_o;

   int checks = 0;
   int errors = 0;

   fetch_stage_if bus ();

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem          (bus),
      .id_instr_o    (id_instr_o),
      .id_op_o       (id_op_o),
      .id_pc_plus4_o (id_pc_plus4_o),
      .id_valid_o    (id_valid_o),
      .misalign_o    (misalign_o),
      .fetch_count_o (fetch_count_o)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: two fixed words, address-tagged ADDI elsewhere.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      if (a == 32'h0000_0000)      return 32'h0000_0020;
      else if (a == 32'h0000_0004) return 32'h8C01_0004;
      else                         return 32'h2000_0000 | (a & 32'h0000_FFFF);
   endfunction

   assign bus.imem_rdata = imem_word(bus.imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_addr"},  bus.imem_addr, 32'h0000_0000);
      chk({tag, "_instr"}, id_instr_o, 32'h0000_0000);
      chk({tag, "_op"},    {26'd0, id_op_o}, 32'h0000_0000);
      chk({tag, "_pc4"},   id_pc_plus4_o, 32'h0000_0000);
      chk({tag, "_valid"}, {31'd0, id_valid_o}, 32'h0000_0000);
      chk({tag, "_mis"},   {31'd0, misalign_o}, 32'h0000_0000);
      chk({tag, "_cnt"},   fetch_count_o, 32'h0000_0000);
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0000_0000;
      step();
      step();
      chk_reset("rst_hold");

      // Sequential fetch from RESET_PC.
      rst = 1'b0;
      step();
      chk("f1_instr", id_instr_o, 32'h0000_0020);
      chk("f1_op",    {26'd0, id_op_o}, 32'h0000_0000);
      chk("f1_pc4",   id_pc_plus4_o, 32'h0000_0004);
      chk("f1_valid", {31'd0, id_valid_o}, 32'h0000_0001);
      chk("f1_cnt",   fetch_count_o, 32'h0000_0001);
      step();
      chk("f2_op",    {26'd0, id_op_o}, 32'h0000_0023);
      chk("f2_instr", id_instr_o, 32'h8C01_0004);
      chk("f2_addr",  bus.imem_addr, 32'h0000_0008);
      chk("f2_cnt",   fetch_count_o, 32'h0000_0002);

      // Three-cycle stall at pc 8.
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_addr",  bus.imem_addr, 32'h0000_0008);
         chk("st_instr", id_instr_o, 32'h8C01_0004);
         chk("st_cnt",   fetch_count_o, 32'h0000_0002);
      end
      stall_i = 1'b0;
      step();
      chk("rs_addr",  bus.imem_addr, 32'h0000_000C);
      chk("rs_instr", id_instr_o, 32'h2000_0008);
      chk("rs_pc4",   id_pc_plus4_o, 32'h0000_000C);
      chk("rs_cnt",   fetch_count_o, 32'h0000_0003);

      // Redirect to 0x40 while stalled: redirect wins, one bubble.
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040; stall_i = 1'b1;
      step();
      chk("rd_addr",  bus.imem_addr, 32'h0000_0040);
      chk("rd_valid", {31'd0, id_valid_o}, 32'h0000_0000);
      chk("rd_instr", id_instr_o, 32'h0000_0000);
      chk("rd_cnt",   fetch_count_o, 32'h0000_0003);
      redirect_i = 1'b0; stall_i = 1'b0;
      step();
      chk("tg_instr", id_instr_o, 32'h2000_0040);
      chk("tg_valid", {31'd0, id_valid_o}, 32'h0000_0001);
      chk("tg_pc4",   id_pc_plus4_o, 32'h0000_0044);
      chk("tg_cnt",   fetch_count_o, 32'h0000_0004);

      // Misaligned redirect target: aligned down, sticky flag.
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0042;
      step();
      chk("ma_addr", bus.imem_addr, 32'h0000_0040);
      chk("ma_mis",  {31'd0, misalign_o}, 32'h0000_0001);
      redirect_i = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("ma_sticky", {31'd0, misalign_o}, 32'h0000_0001);
      chk("ma_addr10", bus.imem_addr, 32'h0000_0068);
      chk("ma_cnt10",  fetch_count_o, 32'h0000_000E);

      // PC wrap at the top of the address space.
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      step();
      chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
      redirect_i = 1'b0;
      step();
      chk("wr_addr0", bus.imem_addr, 32'h0000_0000);
      chk("wr_pc4",   id_pc_plus4_o, 32'h0000_0000);
      chk("wr_instr", id_instr_o, 32'h2000_FFFC);
      chk("wr_cnt",   fetch_count_o, 32'h0000_000F);

      // Reset with stall and redirect asserted: reset wins.
      rst = 1'b1; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0080;
      step();
      chk_reset("rst_mid");
      rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
      step();
      chk("ar_instr", id_instr_o, 32'h0000_0020);
      chk("ar_addr",  bus.imem_addr, 32'h0000_0004);
      chk("ar_valid", {31'd0, id_valid_o}, 32'h0000_0001);
      chk("ar_cnt",   fetch_count_o, 32'h0000_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
